// File: rtl/i2c_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : i2c_pkg
// Brief    : Shared I2C state encoding, rw constants and field widths.
// Revision : 1.0
// ----------------------------------------------------------------------------
package i2c_pkg;
    localparam int I2C_ADDR_W = 7;
    localparam int I2C_DATA_W = 8;

    localparam logic I2C_RW_WRITE = 1'b0;
    localparam logic I2C_RW_READ  = 1'b1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ADDR      = 3'd1,
        ADDR_ACK  = 3'd2,
        WRITE     = 3'd3,
        WRITE_ACK = 3'd4,
        READ      = 3'd5,
        MACK      = 3'd6,
        IGNORE    = 3'd7
    } i2c_state_t;
endpackage
`default_nettype wire

// File: rtl/i2c_bus_sync.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : i2c_bus_sync
// Brief    : scl/sda synchronizer, optional glitch filter
//            (I2C_SLAVE_GLITCH_FILTER_EN), edge and START/STOP detection.
// Revision : 1.0
// ----------------------------------------------------------------------------
module i2c_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic scl,
    input  logic sda,
    output logic sda_level,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);
    logic [SYNC_STAGES-1:0] r_scl_sync;
    logic [SYNC_STAGES-1:0] r_sda_sync;
    logic                   w_scl_sync;
    logic                   w_sda_sync;
    logic                   w_scl_f;
    logic                   w_sda_f;
    logic                   r_scl_d;
    logic                   r_sda_d;

    // Idle bus level is high; resetting to 1 avoids false edges after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda};
        end
    end

    assign w_scl_sync = r_scl_sync[SYNC_STAGES-1];
    assign w_sda_sync = r_sda_sync[SYNC_STAGES-1];

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    logic [1:0] r_scl_hist;
    logic [1:0] r_sda_hist;
    logic       r_scl_filt;
    logic       r_sda_filt;

    // A new level is taken only once three consecutive samples agree.
    assign w_scl_f = (w_scl_sync == r_scl_hist[0] && w_scl_sync == r_scl_hist[1])
                     ? w_scl_sync : r_scl_filt;
    assign w_sda_f = (w_sda_sync == r_sda_hist[0] && w_sda_sync == r_sda_hist[1])
                     ? w_sda_sync : r_sda_filt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_scl_hist <= '1;
            r_sda_hist <= '1;
            r_scl_filt <= 1'b1;
            r_sda_filt <= 1'b1;
        end else begin
            r_scl_hist <= {r_scl_hist[0], w_scl_sync};
            r_sda_hist <= {r_sda_hist[0], w_sda_sync};
            r_scl_filt <= w_scl_f;
            r_sda_filt <= w_sda_f;
        end
    end
`else
    assign w_scl_f = w_scl_sync;
    assign w_sda_f = w_sda_sync;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_scl_d <= 1'b1;
            r_sda_d <= 1'b1;
        end else begin
            r_scl_d <= w_scl_f;
            r_sda_d <= w_sda_f;
        end
    end

    assign sda_level = w_sda_f;
    assign scl_rise  = w_scl_f & ~r_scl_d;
    assign scl_fall  = ~w_scl_f & r_scl_d;
    assign start_det = r_scl_d & w_scl_f & r_sda_d & ~w_sda_f;
    assign stop_det  = r_scl_d & w_scl_f & ~r_sda_d & w_sda_f;
endmodule
`default_nettype wire

// File: rtl/i2c_slave.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : i2c_slave
// Brief    : 7-bit address I2C target with write capture and read shift-out.
//            Optional input glitch filter: I2C_SLAVE_GLITCH_FILTER_EN.
// Revision : 1.0
// ----------------------------------------------------------------------------
module i2c_slave
    import i2c_pkg::*;
#(
    parameter logic [I2C_ADDR_W-1:0] DEV_ADDR    = 7'h50,
    parameter int                    SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  scl,
    inout  wire                   sda,
    input  logic [I2C_DATA_W-1:0] tx_data,
    output logic [I2C_DATA_W-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  tx_req,
    output logic                  addressed,
    output logic                  busy
);
    logic w_sda_level;
    logic w_scl_rise;
    logic w_scl_fall;
    logic w_start_det;
    logic w_stop_det;

    i2c_bus_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_bus_sync (
        .clk       (clk),
        .rst       (rst),
        .scl       (scl),
        .sda       (sda),
        .sda_level (w_sda_level),
        .scl_rise  (w_scl_rise),
        .scl_fall  (w_scl_fall),
        .start_det (w_start_det),
        .stop_det  (w_stop_det)
    );

    i2c_state_t            r_state,     w_state;
    logic [3:0]            r_bit_cnt,   w_bit_cnt;
    logic [I2C_DATA_W-1:0] r_shift,     w_shift;
    logic [I2C_DATA_W-1:0] r_rx_data,   w_rx_data;
    logic                  r_rw,        w_rw;
    logic                  r_ack_phase, w_ack_phase;
    logic                  r_sda_low,   w_sda_low;
    logic                  r_rx_valid,  w_rx_valid;
    logic                  r_tx_req,    w_tx_req;
    logic                  r_addressed, w_addressed;
    logic                  r_busy,      w_busy;
    logic [I2C_DATA_W-1:0] w_shift_in;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_bit_cnt   <= 4'd0;
            r_shift     <= '0;
            r_rx_data   <= '0;
            r_rw        <= 1'b0;
            r_ack_phase <= 1'b0;
            r_sda_low   <= 1'b0;
            r_rx_valid  <= 1'b0;
            r_tx_req    <= 1'b0;
            r_addressed <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_bit_cnt   <= w_bit_cnt;
            r_shift     <= w_shift;
            r_rx_data   <= w_rx_data;
            r_rw        <= w_rw;
            r_ack_phase <= w_ack_phase;
            r_sda_low   <= w_sda_low;
            r_rx_valid  <= w_rx_valid;
            r_tx_req    <= w_tx_req;
            r_addressed <= w_addressed;
            r_busy      <= w_busy;
        end
    end

    assign w_shift_in = {r_shift[I2C_DATA_W-2:0], w_sda_level};

    always_comb begin
        w_state     = r_state;
        w_bit_cnt   = r_bit_cnt;
        w_shift     = r_shift;
        w_rx_data   = r_rx_data;
        w_rw        = r_rw;
        w_ack_phase = r_ack_phase;
        w_sda_low   = r_sda_low;
        w_rx_valid  = 1'b0;
        w_tx_req    = 1'b0;
        w_addressed = r_addressed;
        w_busy      = r_busy;

        if (w_start_det) begin
            w_state     = ADDR;
            w_bit_cnt   = 4'd0;
            w_sda_low   = 1'b0;
            w_ack_phase = 1'b0;
            w_addressed = 1'b0;
            w_busy      = 1'b1;
        end else if (w_stop_det) begin
            w_state     = IDLE;
            w_bit_cnt   = 4'd0;
            w_sda_low   = 1'b0;
            w_ack_phase = 1'b0;
            w_addressed = 1'b0;
            w_busy      = 1'b0;
        end else begin
            case (r_state)
                ADDR: begin
                    if (w_scl_rise) begin
                        w_shift   = w_shift_in;
                        w_bit_cnt = r_bit_cnt + 4'd1;
                        if (r_bit_cnt == 4'd7) begin
                            w_bit_cnt   = 4'd0;
                            w_rw        = w_sda_level;
                            w_ack_phase = 1'b0;
                            w_state     = (w_shift_in[7:1] == DEV_ADDR) ? ADDR_ACK : IGNORE;
                        end
                    end
                end
                ADDR_ACK, WRITE_ACK: begin
                    // First fall starts the ACK slot, second fall ends it.
                    if (w_scl_fall) begin
                        if (!r_ack_phase) begin
                            w_sda_low   = 1'b1;
                            w_ack_phase = 1'b1;
                            if (r_state == ADDR_ACK) begin
                                w_addressed = 1'b1;
                            end
                        end else begin
                            w_ack_phase = 1'b0;
                            w_bit_cnt   = 4'd0;
                            if (r_state == ADDR_ACK && r_rw == I2C_RW_READ) begin
                                w_shift   = tx_data;
                                w_tx_req  = 1'b1;
                                w_sda_low = ~tx_data[7];
                                w_state   = READ;
                            end else begin
                                w_sda_low = 1'b0;
                                w_state   = WRITE;
                            end
                        end
                    end
                end
                WRITE: begin
                    if (w_scl_rise) begin
                        w_shift   = w_shift_in;
                        w_bit_cnt = r_bit_cnt + 4'd1;
                        if (r_bit_cnt == 4'd7) begin
                            w_bit_cnt   = 4'd0;
                            w_rx_data   = w_shift_in;
                            w_rx_valid  = 1'b1;
                            w_ack_phase = 1'b0;
                            w_state     = WRITE_ACK;
                        end
                    end
                end
                READ: begin
                    // Count 0 on a fall only occurs after a master ACK: bit 7 not yet driven.
                    if (w_scl_rise) begin
                        w_bit_cnt = r_bit_cnt + 4'd1;
                    end else if (w_scl_fall) begin
                        if (r_bit_cnt == 4'd8) begin
                            w_sda_low = 1'b0;
                            w_bit_cnt = 4'd0;
                            w_state   = MACK;
                        end else if (r_bit_cnt == 4'd0) begin
                            w_sda_low = ~r_shift[7];
                        end else begin
                            w_shift   = r_shift << 1;
                            w_sda_low = ~r_shift[6];
                        end
                    end
                end
                MACK: begin
                    if (w_scl_rise) begin
                        w_bit_cnt = 4'd0;
                        if (!w_sda_level) begin
                            w_shift  = tx_data;
                            w_tx_req = 1'b1;
                            w_state  = READ;
                        end else begin
                            w_addressed = 1'b0;
                            w_state     = IGNORE;
                        end
                    end
                end
                IDLE, IGNORE: begin
                end
                default: begin
                    w_state = IDLE;
                end
            endcase
        end
    end

    assign sda       = r_sda_low ? 1'b0 : 1'bz;
    assign rx_data   = r_rx_data;
    assign rx_valid  = r_rx_valid;
    assign tx_req    = r_tx_req;
    assign addressed = r_addressed;
    assign busy      = r_busy;
endmodule
`default_nettype wire

// File: tb/tb_i2c_slave.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : tb_i2c_slave
// Brief    : Bus-level master model driving directed transactions into i2c_slave.
// Revision : 1.0
// ----------------------------------------------------------------------------
module tb_i2c_slave;
    import i2c_pkg::*;

    logic       clk;
    logic       rst;
    logic       scl;
    logic       m_low;
    logic [7:0] tx_data;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_req;
    logic       addressed;
    logic       busy;
    wire        sda_bus;

    int n_vec;
    int n_err;
    int rxv_cnt;
    int txr_cnt;
    int dut_low_cnt;

    pullup (sda_bus);
    assign sda_bus = m_low ? 1'b0 : 1'bz;

    i2c_slave #(
        .DEV_ADDR    (7'h50),
        .SYNC_STAGES (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .scl       (scl),
        .sda       (sda_bus),
        .tx_data   (tx_data),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .tx_req    (tx_req),
        .addressed (addressed),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) begin
            rxv_cnt     <= rxv_cnt;
        end
        if (rx_valid) rxv_cnt <= rxv_cnt + 1;
        if (tx_req)   txr_cnt <= txr_cnt + 1;
        if (sda_bus === 1'b0 && !m_low) dut_low_cnt <= dut_low_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_q();
        repeat (4) @(negedge clk);
    endtask

    task automatic bus_start();
        m_low = 1'b0; scl = 1'b1; wait_q();
        m_low = 1'b1; wait_q();
        scl = 1'b0; wait_q();
    endtask

    task automatic bus_rstart();
        m_low = 1'b0; wait_q();
        scl = 1'b1; wait_q();
        m_low = 1'b1; wait_q();
        scl = 1'b0; wait_q();
    endtask

    task automatic bus_stop();
        m_low = 1'b1; wait_q();
        scl = 1'b1; wait_q();
        m_low = 1'b0; wait_q();
    endtask

    task automatic send_bit(input logic b, output logic rb);
        m_low = ~b; wait_q();
        scl = 1'b1; wait_q();
        rb = sda_bus; wait_q();
        scl = 1'b0; wait_q();
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic rb;
        for (int i = 7; i >= 0; i--) send_bit(b[i], rb);
        send_bit(1'b1, rb);
        ack = ~rb;
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d, output logic mack_rel);
        logic rb;
        for (int i = 7; i >= 0; i--) begin
            send_bit(1'b1, rb);
            d[i] = rb;
        end
        send_bit(nack, rb);
        mack_rel = rb;
    endtask

    typedef struct {
        logic [6:0] addr;
        logic [7:0] data;
        logic       exp_ack;
        logic [7:0] exp_rx;
        int         exp_rxv;
    } wvec_t;

    wvec_t vecs [5];

    initial begin
        logic       ack;
        logic       rel;
        logic [7:0] d;
        int         rxv0;
        int         txr0;
        int         low0;

        vecs[0] = '{7'h50, 8'h55, 1'b1, 8'h55, 1};
        vecs[1] = '{7'h51, 8'hAA, 1'b0, 8'h55, 0};
        vecs[2] = '{7'h00, 8'h33, 1'b0, 8'h55, 0};
        vecs[3] = '{7'h50, 8'h00, 1'b1, 8'h00, 1};
        vecs[4] = '{7'h50, 8'hFF, 1'b1, 8'hFF, 1};

        n_vec = 0; n_err = 0;
        rxv_cnt = 0; txr_cnt = 0; dut_low_cnt = 0;
        rst = 1'b1; scl = 1'b1; m_low = 1'b0; tx_data = 8'h00;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        wait_q();
        check("reset_outputs", {rx_data, rx_valid, tx_req, addressed, busy}, 32'h0);
        check("reset_sda", sda_bus, 1'b1);
        check("reset_state", 32'(dut.r_state), 32'(IDLE));

        // Single-byte writes: own address, foreign address, general call, data extremes.
        for (int v = 0; v < 5; v++) begin
            rxv0 = rxv_cnt;
            low0 = dut_low_cnt;
            bus_start();
            check("busy_after_start", busy, 1'b1);
            write_byte({vecs[v].addr, I2C_RW_WRITE}, ack);
            check("addr_ack", ack, vecs[v].exp_ack);
            check("addressed_after_addr", addressed, vecs[v].exp_ack);
            if (vecs[v].exp_ack) begin
                write_byte(vecs[v].data, ack);
                check("data_ack", ack, 1'b1);
            end else begin
                check("ignore_state", 32'(dut.r_state), 32'(IGNORE));
                check("sda_never_low", dut_low_cnt - low0, 0);
            end
            bus_stop();
            check("rx_valid_count", rxv_cnt - rxv0, vecs[v].exp_rxv);
            check("rx_data", rx_data, vecs[v].exp_rx);
            check("addressed_after_stop", addressed, 1'b0);
            check("busy_after_stop", busy, 1'b0);
            check("idle_after_stop", 32'(dut.r_state), 32'(IDLE));
        end

        // Read one byte, master NACKs.
        tx_data = 8'hA5;
        txr0 = txr_cnt;
        bus_start();
        write_byte({7'h50, I2C_RW_READ}, ack);
        check("read_addr_ack", ack, 1'b1);
        tx_data = 8'h3C;
        read_byte(1'b1, d, rel);
        check("read_data", d, 8'hA5);
        check("mack_released", rel, 1'b1);
        check("tx_req_count", txr_cnt - txr0, 1);
        check("ignore_after_nack", 32'(dut.r_state), 32'(IGNORE));
        check("addressed_after_nack", addressed, 1'b0);
        bus_stop();

        // Two-byte write.
        rxv0 = rxv_cnt;
        bus_start();
        write_byte({7'h50, I2C_RW_WRITE}, ack);
        check("mb_addr_ack", ack, 1'b1);
        write_byte(8'h12, ack);
        check("mb_ack1", ack, 1'b1);
        check("mb_rx1", rx_data, 8'h12);
        check("mb_cnt1", rxv_cnt - rxv0, 1);
        write_byte(8'h34, ack);
        check("mb_ack2", ack, 1'b1);
        check("mb_rx2", rx_data, 8'h34);
        check("mb_cnt2", rxv_cnt - rxv0, 2);
        bus_stop();

        // Repeated START after 4 data bits aborts the byte.
        rxv0 = rxv_cnt;
        bus_start();
        write_byte({7'h50, I2C_RW_WRITE}, ack);
        check("rs_addr_ack", ack, 1'b1);
        send_bit(1'b1, rel); send_bit(1'b0, rel);
        send_bit(1'b1, rel); send_bit(1'b0, rel);
        bus_rstart();
        check("rs_no_rx_valid", rxv_cnt - rxv0, 0);
        check("rs_state_addr", 32'(dut.r_state), 32'(ADDR));
        write_byte({7'h50, I2C_RW_WRITE}, ack);
        check("rs_addr2_ack", ack, 1'b1);
        write_byte(8'h0F, ack);
        check("rs_data_ack", ack, 1'b1);
        bus_stop();
        check("rs_rx_count", rxv_cnt - rxv0, 1);
        check("rs_rx_data", rx_data, 8'h0F);

        // Reset while the target is driving the address ACK.
        bus_start();
        for (int i = 7; i >= 0; i--) begin
            d = 8'hA0;
            send_bit(d[i], rel);
        end
        m_low = 1'b0;
        wait_q();
        check("ack_driven_before_rst", sda_bus, 1'b0);
        check("addressed_before_rst", addressed, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_sda_released", sda_bus, 1'b1);
        check("rst_outputs", {rx_data, rx_valid, tx_req, addressed, busy}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        scl = 1'b1; wait_q();
        scl = 1'b0; wait_q();
        bus_stop();
        rxv0 = rxv_cnt;
        bus_start();
        write_byte({7'h50, I2C_RW_WRITE}, ack);
        check("post_rst_addr_ack", ack, 1'b1);
        write_byte(8'h5A, ack);
        check("post_rst_data_ack", ack, 1'b1);
        bus_stop();
        check("post_rst_rx_data", rx_data, 8'h5A);
        check("post_rst_rx_count", rxv_cnt - rxv0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
